pc_trace_monitor: RTL and testbench

//  Synthesisable run monitor for the RISC-V core. Counts run cycles and samples
//  {cycle, pc} every SAMPLE_INTERVAL cycles into a trace FIFO with a valid/ready

---
 rtl/pc_trace_monitor_pkg.sv | 21 ++
 rtl/pc_trace_monitor_trace_fifo.sv | 56 +++++
 rtl/pc_trace_monitor.sv | 160 ++++++++++++++++
 tb/tb_pc_trace_monitor.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/pc_trace_monitor_pkg.sv
// Shared types for the PC trace monitor: run-state encoding, drop counter width
// and the packed sample layout {cycle, pc} (cycle in the upper bits).
package pc_trace_monitor_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } mon_state_e;

    localparam int DROP_W = 16;

    function automatic int sample_width(input int cw, input int xlen);
        return cw + xlen;
    endfunction

    function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
        return (&v) ? v : v + DROP_W'(1);
    endfunction

endpackage

// File: rtl/pc_trace_monitor_trace_fifo.sv
// Synchronous first-word-fall-through FIFO; a push while full is accepted only
// when a pop frees a slot in the same cycle.
module trace_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign empty = (count_q == '0);
    assign full  = (count_q == (AW+1)'(DEPTH));
    // Head is forced to zero when empty so stale entries never leak out.
    assign dout  = empty ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        do_pop   = pop & ~empty;
        do_push  = push & (~full | do_pop);
        wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

endmodule

// File: rtl/pc_trace_monitor.sv
// Run monitor for the core: counts run cycles, periodically samples {cycle, pc}
// into a trace FIFO, and ends the run on stop, cycle budget or a stalled PC.
module pc_trace_monitor
    import pc_trace_monitor_pkg::*;
#(
    parameter int XLEN            = 32,
    parameter int CW              = 32,
    parameter int SAMPLE_INTERVAL = 100,
    parameter int TRACE_DEPTH     = 16,
    parameter int STALL_LIMIT     = 64,
    parameter int MAX_CYCLES      = 500,
    parameter int HALT_ON_STALL   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    input  logic [XLEN-1:0]   pc,
    input  logic              pc_valid,
    input  logic              trc_ready,
    output logic              trc_valid,
    output logic [CW-1:0]     trc_cycle,
    output logic [XLEN-1:0]   trc_pc,
    output logic [CW-1:0]     cycle_count,
    output logic [DROP_W-1:0] drop_count,
    output logic              stall_flag,
    output logic              timeout_flag,
    output logic              done
);

    localparam int SW = $clog2(SAMPLE_INTERVAL + 1);
    localparam int LW = $clog2(STALL_LIMIT + 1);
    localparam int DW = sample_width(CW, XLEN);

    mon_state_e        state_q, state_d;
    logic [CW-1:0]     cycle_q, cycle_d;
    logic [SW-1:0]     interval_q, interval_d;
    logic [LW-1:0]     stall_q, stall_d;
    logic [DROP_W-1:0] drop_q, drop_d;
    logic              stall_flag_q, stall_flag_d;
    logic              timeout_q, timeout_d;
    logic [XLEN-1:0]   last_pc_q, last_pc_d;

    logic              sample;
    logic              stall_hit;
    logic              timeout_hit;
    logic              trc_pop;
    logic              fifo_empty, fifo_full;
    logic [DW-1:0]     fifo_dout;

    assign trc_valid = ~fifo_empty;
    assign trc_pop   = trc_valid & trc_ready;

    always_comb begin
        state_d      = state_q;
        cycle_d      = cycle_q;
        interval_d   = interval_q;
        stall_d      = stall_q;
        drop_d       = drop_q;
        stall_flag_d = stall_flag_q;
        timeout_d    = timeout_q;
        last_pc_d    = pc_valid ? pc : last_pc_q;
        sample       = 1'b0;
        stall_hit    = 1'b0;
        timeout_hit  = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d      = ST_RUN;
                    cycle_d      = '0;
                    interval_d   = SW'(SAMPLE_INTERVAL);
                    stall_d      = '0;
                    drop_d       = '0;
                    stall_flag_d = 1'b0;
                    timeout_d    = 1'b0;
                end
            end
            ST_RUN: begin
                cycle_d = cycle_q + CW'(1);
                // Down-counter reload keeps samples on k*SAMPLE_INTERVAL without a divider.
                if (interval_q == SW'(1)) begin
                    sample     = 1'b1;
                    interval_d = SW'(SAMPLE_INTERVAL);
                end else begin
                    interval_d = interval_q - SW'(1);
                end

                if (pc_valid && (pc != last_pc_q)) begin
                    stall_d = '0;
                end else if (stall_q != LW'(STALL_LIMIT)) begin
                    stall_d = stall_q + LW'(1);
                end
                stall_hit = (stall_d == LW'(STALL_LIMIT));
                if (stall_hit) begin
                    stall_flag_d = 1'b1;
                end

                timeout_hit = (MAX_CYCLES != 0) && (cycle_d == CW'(MAX_CYCLES));
                if (timeout_hit) begin
                    timeout_d = 1'b1;
                end

                if (sample && fifo_full && !trc_pop) begin
                    drop_d = sat_inc(drop_q);
                end

                if (stop || timeout_hit || (stall_hit && (HALT_ON_STALL != 0))) begin
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            cycle_q      <= '0;
            interval_q   <= '0;
            stall_q      <= '0;
            drop_q       <= '0;
            stall_flag_q <= 1'b0;
            timeout_q    <= 1'b0;
            last_pc_q    <= '0;
        end else begin
            state_q      <= state_d;
            cycle_q      <= cycle_d;
            interval_q   <= interval_d;
            stall_q      <= stall_d;
            drop_q       <= drop_d;
            stall_flag_q <= stall_flag_d;
            timeout_q    <= timeout_d;
            last_pc_q    <= last_pc_d;
        end
    end

    trace_fifo #(
        .WIDTH (DW),
        .DEPTH (TRACE_DEPTH)
    ) u_trace_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (sample),
        .pop   (trc_pop),
        .din   ({cycle_d, pc}),
        .dout  (fifo_dout),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    assign trc_cycle    = fifo_dout[DW-1 -: CW];
    assign trc_pc       = fifo_dout[XLEN-1:0];
    assign cycle_count  = cycle_q;
    assign drop_count   = drop_q;
    assign stall_flag   = stall_flag_q;
    assign timeout_flag = timeout_q;
    assign done         = (state_q == ST_DONE);

endmodule

// File: tb/tb_pc_trace_monitor.sv
// Directed bench: instance A covers sampling, stall, timeout and reset; instance B
// (depth 4, interval 1) covers drops and push-while-full-with-pop.
module tb_pc_trace_monitor;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc;
    logic        pc_valid;

    logic        start_a, stop_a, rdy_a;
    logic        valid_a, stall_a, tmo_a, done_a;
    logic [31:0] tcyc_a, tpc_a, cyc_a;
    logic [15:0] drop_a;

    logic        start_b, stop_b, rdy_b;
    logic        valid_b, stall_b, tmo_b, done_b;
    logic [31:0] tcyc_b, tpc_b, cyc_b;
    logic [15:0] drop_b;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    pc_trace_monitor #(
        .XLEN(32), .CW(32), .SAMPLE_INTERVAL(100), .TRACE_DEPTH(16),
        .STALL_LIMIT(64), .MAX_CYCLES(500), .HALT_ON_STALL(1)
    ) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .stop(stop_a),
        .pc(pc), .pc_valid(pc_valid), .trc_ready(rdy_a),
        .trc_valid(valid_a), .trc_cycle(tcyc_a), .trc_pc(tpc_a),
        .cycle_count(cyc_a), .drop_count(drop_a), .stall_flag(stall_a),
        .timeout_flag(tmo_a), .done(done_a)
    );

    pc_trace_monitor #(
        .XLEN(32), .CW(32), .SAMPLE_INTERVAL(1), .TRACE_DEPTH(4),
        .STALL_LIMIT(64), .MAX_CYCLES(0), .HALT_ON_STALL(0)
    ) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .stop(stop_b),
        .pc(pc), .pc_valid(pc_valid), .trc_ready(rdy_b),
        .trc_valid(valid_b), .trc_cycle(tcyc_b), .trc_pc(tpc_b),
        .cycle_count(cyc_b), .drop_count(drop_b), .stall_flag(stall_b),
        .timeout_flag(tmo_b), .done(done_b)
    );

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, act);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        rst = 1'b0; pc = '0; pc_valid = 1'b0;
        start_a = 1'b0; stop_a = 1'b0; rdy_a = 1'b0;
        start_b = 1'b0; stop_b = 1'b0; rdy_b = 1'b0;
        repeat (3) tick();

        // Reset state
        check_val("rst_valid",   64'(valid_a), 64'd0);
        check_val("rst_cycle",   64'(cyc_a),   64'd0);
        check_val("rst_drop",    64'(drop_a),  64'd0);
        check_val("rst_flags",   64'({stall_a, tmo_a, done_a}), 64'd0);
        check_val("rst_trc",     64'({tcyc_a, tpc_a}), 64'd0);
        rst = 1'b1;
        tick();

        // Test 1: interval 100, run 250 cycles then stop
        pc_valid = 1'b1;
        start_a = 1'b1; tick(); start_a = 1'b0;
        check_val("t1_start_cyc", 64'(cyc_a), 64'd0);
        for (int i = 1; i <= 250; i++) begin
            pc = 32'h1000 + 32'(4 * i);
            stop_a = (i == 250);
            tick();
        end
        stop_a = 1'b0;
        check_val("t1_cycle", 64'(cyc_a), 64'd250);
        check_val("t1_done",  64'(done_a), 64'd1);
        check_val("t1_flags", 64'({stall_a, tmo_a}), 64'd0);
        tick();
        check_val("t1_hold",  64'(cyc_a), 64'd250);
        check_val("t1_valid", 64'(valid_a), 64'd1);
        check_val("t1_s0",    64'({tcyc_a, tpc_a}), {32'd100, 32'h1000 + 32'd400});
        rdy_a = 1'b1; tick(); rdy_a = 1'b0;
        check_val("t1_s1",    64'({tcyc_a, tpc_a}), {32'd200, 32'h1000 + 32'd800});
        rdy_a = 1'b1; tick(); rdy_a = 1'b0;
        check_val("t1_empty", 64'(valid_a), 64'd0);

        // Test 3: frozen pc -> stall halts at cycle 64
        pc = 32'h40;
        tick();
        start_a = 1'b1; tick(); start_a = 1'b0;
        n = 0;
        while (!done_a && n < 200) begin tick(); n++; end
        check_val("t3_done",  64'(done_a), 64'd1);
        check_val("t3_stall", 64'(stall_a), 64'd1);
        check_val("t3_cycle", 64'(cyc_a), 64'd64);
        check_val("t3_tmo",   64'(tmo_a), 64'd0);

        // Test 4: timeout at 500 with 5 samples
        start_a = 1'b1; tick(); start_a = 1'b0;
        n = 0;
        while (!done_a && n < 700) begin
            n++;
            pc = 32'h2000 + 32'(4 * n);
            tick();
        end
        check_val("t4_tmo",   64'(tmo_a), 64'd1);
        check_val("t4_done",  64'(done_a), 64'd1);
        check_val("t4_cycle", 64'(cyc_a), 64'd500);
        check_val("t4_stall", 64'(stall_a), 64'd0);
        for (int k = 1; k <= 5; k++) begin
            check_val("t4_valid", 64'(valid_a), 64'd1);
            check_val("t4_samp",  64'({tcyc_a, tpc_a}), {32'(100 * k), 32'h2000 + 32'(400 * k)});
            rdy_a = 1'b1; tick(); rdy_a = 1'b0;
        end
        check_val("t4_empty", 64'(valid_a), 64'd0);

        // Test 2: depth 4, interval 1, no drain for 10 cycles
        start_b = 1'b1; tick(); start_b = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            pc = 32'h3000 + 32'(4 * i);
            stop_b = (i == 10);
            tick();
        end
        stop_b = 1'b0;
        check_val("t2_cycle", 64'(cyc_b), 64'd10);
        check_val("t2_done",  64'(done_b), 64'd1);
        check_val("t2_drop",  64'(drop_b), 64'd6);
        check_val("t2_head",  64'({tcyc_b, tpc_b}), {32'd1, 32'h3004});

        // Test 6: full FIFO, push and pop in the same cycle
        start_b = 1'b1; tick(); start_b = 1'b0;
        check_val("t6_drop_clr", 64'(drop_b), 64'd0);
        check_val("t6_kept",     64'({tcyc_b, tpc_b}), {32'd1, 32'h3004});
        for (int i = 1; i <= 3; i++) begin
            pc = 32'h5000 + 32'(4 * i);
            rdy_b = 1'b1;
            stop_b = (i == 3);
            tick();
        end
        rdy_b = 1'b0; stop_b = 1'b0;
        check_val("t6_drop",  64'(drop_b), 64'd0);
        check_val("t6_cycle", 64'(cyc_b), 64'd3);
        check_val("t6_e0", 64'({tcyc_b, tpc_b}), {32'd4, 32'h3010});
        rdy_b = 1'b1; tick();
        check_val("t6_e1", 64'({tcyc_b, tpc_b}), {32'd1, 32'h5004});
        tick();
        check_val("t6_e2", 64'({tcyc_b, tpc_b}), {32'd2, 32'h5008});
        tick();
        check_val("t6_e3", 64'({tcyc_b, tpc_b}), {32'd3, 32'h500c});
        tick(); rdy_b = 1'b0;
        check_val("t6_empty", 64'(valid_b), 64'd0);

        // Test 5: reset mid-run at cycle 150 with a sample queued
        start_a = 1'b1; tick(); start_a = 1'b0;
        for (int i = 1; i <= 150; i++) begin
            pc = 32'h6000 + 32'(4 * i);
            tick();
        end
        check_val("t5_cycle", 64'(cyc_a), 64'd150);
        check_val("t5_queued", 64'(valid_a), 64'd1);
        rst = 1'b0; tick();
        check_val("t5_valid", 64'(valid_a), 64'd0);
        check_val("t5_trc",   64'({tcyc_a, tpc_a}), 64'd0);
        check_val("t5_cnts",  64'({cyc_a, drop_a}), 64'd0);
        check_val("t5_flags", 64'({stall_a, tmo_a, done_a}), 64'd0);
        rst = 1'b1; tick();
        start_a = 1'b1; tick(); start_a = 1'b0;
        tick();
        check_val("t5_restart", 64'(cyc_a), 64'd1);
        check_val("t5_run",     64'({valid_a, done_a}), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
